// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op field width and op codes emitted by the decoder into the pipeline
//   - default busy-window lengths for multiply- and divide-class ops
//   - FSM state type, exposed on the interface for observation
// Optional feature macro: MDU_MADD_EN (enables op codes 7-10, MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
    localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
    localparam logic [OP_W-1:0] OP_MADD  = 4'd7;
    localparam logic [OP_W-1:0] OP_MADDU = 4'd8;
    localparam logic [OP_W-1:0] OP_MSUB  = 4'd9;
    localparam logic [OP_W-1:0] OP_MSUBU = 4'd10;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the E stage and the MDU.
//   master (E stage): drives start, op, rs, rt; observes busy, hi, lo, state
//   slave  (mdu)    : the reverse
// Handshake: start is a one-cycle request qualified by op. It is accepted
// only when busy is 0; a start while busy is dropped. busy rises one cycle
// after the accepted start, so stall logic must use (busy | start).
// Optional feature macro: MDU_MADD_EN (see mdu_pkg).
interface mdu_if;
    import mdu_pkg::*;

    logic              start;
    logic [OP_W-1:0]   op;
    logic [31:0]       rs;
    logic [31:0]       rt;
    logic              busy;
    logic [31:0]       hi;
    logic [31:0]       lo;
    mdu_state_e        state;   // debug view of the MDU FSM

    modport master (output start, op, rs, rt, input busy, hi, lo, state);
    modport slave  (input start, op, rs, rt, output busy, hi, lo, state);
endinterface

// File: rtl/mdu_calc.sv
// mdu_calc: combinational datapath of the MDU.
//   op  : operation code
//   rs  : dividend / multiplicand / MTHI-MTLO source
//   rt  : divisor / multiplier
//   hi, lo : current HI/LO (accumulate ops only)
//   res : 64-bit result {HI, LO}
//   dz  : divisor is zero
// Optional feature macro: MDU_MADD_EN adds the accumulate datapath.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     rs,
    input  logic [31:0]     rt,
    input  logic [31:0]     hi,
    input  logic [31:0]     lo,
    output logic [63:0]     res,
    output logic            dz
);
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] udiv_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;

    assign dz = (rt == 32'd0);

    // Sign-extend to 64 bits; the low 64 bits of the product are exact.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide through magnitudes so truncation toward zero and the
    // 0x80000000 / -1 case are well defined (|0x80000000| is 0x80000000
    // unsigned, quotient sign stays positive -> 0x80000000, remainder 0).
    assign abs_a  = rs[31] ? (32'd0 - rs) : rs;
    assign abs_b  = rt[31] ? (32'd0 - rt) : rt;
    // A zero divisor is replaced by 1 only to keep the divider free of X;
    // the commit is suppressed by dz anyway.
    assign div_b  = dz ? 32'd1 : abs_b;
    assign udiv_b = dz ? 32'd1 : rt;
    assign q_mag  = abs_a / div_b;
    assign r_mag  = abs_a % div_b;
    assign q_s    = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s    = rs[31] ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
    always_comb begin
        res = 64'd0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {r_s, q_s};
            OP_DIVU:  res = {rs % udiv_b, rs / udiv_b};
            OP_MADD:  res = {hi, lo} + prod_s;
            OP_MADDU: res = {hi, lo} + prod_u;
            OP_MSUB:  res = {hi, lo} - prod_s;
            OP_MSUBU: res = {hi, lo} - prod_u;
            default:  res = 64'd0;
        endcase
    end
`else
    logic unused_acc;
    assign unused_acc = ^{hi, lo};

    always_comb begin
        res = 64'd0;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {r_s, q_s};
            OP_DIVU:  res = {rs % udiv_b, rs / udiv_b};
            default:  res = 64'd0;
        endcase
    end
`endif

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with private HI/LO and a multi-cycle busy window.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   m     : mdu_if.slave (start/op/rs/rt in; busy/hi/lo/state out)
// The result is computed at the accepted start edge and parked in pending
// registers; HI/LO take it on the cnt 1->0 edge (unless divide by zero).
// MTHI/MTLO write immediately and never raise busy.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,  // must be 1..15
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF    // must be 1..15
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  m
);
    mdu_state_e  state_q;
    logic [3:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_dz;
    logic [63:0] res;
    logic        dz;
    logic        is_mul;
    logic        is_div;

    mdu_calc u_calc (
        .op  (m.op),
        .rs  (m.rs),
        .rt  (m.rt),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (res),
        .dz  (dz)
    );

    always_comb begin
        is_mul = (m.op == OP_MULT) || (m.op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (m.op == OP_MADD) || (m.op == OP_MADDU) ||
                 (m.op == OP_MSUB) || (m.op == OP_MSUBU);
`endif
        is_div = (m.op == OP_DIV) || (m.op == OP_DIVU);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt     <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi    <= 32'd0;
            p_lo    <= 32'd0;
            p_dz    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m.start) begin
                        if (is_mul || is_div) begin
                            p_hi    <= res[63:32];
                            p_lo    <= res[31:0];
                            p_dz    <= is_div && dz;
                            cnt     <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                            state_q <= ST_BUSY;
                        end else if (m.op == OP_MTHI) begin
                            hi_q <= m.rs;
                        end else if (m.op == OP_MTLO) begin
                            lo_q <= m.rs;
                        end
                    end
                end
                ST_BUSY: begin
                    // start is ignored here: no restart, no operand capture
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_q <= ST_IDLE;
                        if (!p_dz) begin
                            hi_q <= p_hi;
                            lo_q <= p_lo;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m.busy  = (cnt != 4'd0);
    assign m.hi    = hi_q;
    assign m.lo    = lo_q;
    assign m.state = state_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline, beside the ALU. Executes mult/multu/div/divu/mthi/mtlo into private HI/LO registers with a multi-cycle busy window. Its hi/lo outputs are muxed with the ALU result into the E/M register for mfhi/mflo. The hazard unit stalls D on `busy | start` whenever the D-stage instruction uses HI/LO.

## Interface
- MULT_CYCLES, 5, busy length for multiply-class ops
- DIV_CYCLES, 10, busy length for divide-class ops
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request, qualified by `op`
- op  in  4  operation code (see Operation)
- rs  in  32  forwarded GPR[rs]
- rt  in  32  forwarded GPR[rt]
- busy  out  1  operation in flight
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11–15 are reserved and treated as NONE.
- State is IDLE or BUSY. A 4-bit counter `cnt` drives it, and `busy = (cnt != 0)`.
- In IDLE with `start`:
  - MULT/MULTU/MADD* compute a 64-bit result into pending regs `p_hi`/`p_lo` and set `cnt = MULT_CYCLES`.
  - DIV/DIVU set `cnt = DIV_CYCLES`.
  - MTHI writes `hi <= rs` and MTLO writes `lo <= rs` at that edge. Neither raises busy.
- In BUSY, `cnt` decrements each edge. On the 1→0 edge, `hi <= p_hi` and `lo <= p_lo`, then the unit returns to IDLE.
- A `start` while busy is ignored: no state change and no restart. The hazard unit guarantees this never happens.
- MULT: signed 32×32→64. MULTU: unsigned. Result is {HI,LO}.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned. Operands are rs/rt.
- Divide by zero (rt = 0): the busy window still runs, but HI/LO are left unchanged at commit.
- Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- MADD/MSUB: {p_hi,p_lo} = {hi,lo} ± signed product, sampling HI/LO at the start edge. MADDU/MSUBU use the unsigned product. All wrap modulo 2^64.
- Operands are latched at the start edge, so later rs/rt changes have no effect.

## Timing
- Reset (async, reset = 0): hi = 0, lo = 0, cnt = 0, busy = 0, pending regs = 0. Reset during BUSY aborts the operation and commits nothing.
- Start sampled at edge T: busy = 1 after edge T through edge T+N−1, and drops after edge T+N. New hi/lo are visible after edge T+N.
- MTHI/MTLO: hi/lo update after edge T. Busy stays 0.
- hi/lo outputs are registers, with no combinational path from rs/rt/start.
- A back-to-back start is accepted in the first cycle after busy falls.
- The hazard unit must OR `start` in, because busy rises one cycle late.

## Configuration
- `MDU_MADD_EN` defined: op codes 7–10 are executed as described.
- `MDU_MADD_EN` undefined: op codes 7–10 are treated as NONE (no busy, no state change), and the accumulate datapath is not synthesized.

## Structure
- Op codes, MULT_CYCLES and DIV_CYCLES defaults, and the op-field width go in the shared macro header, alongside the existing instruction decode macros. The decoder emits these codes into the pipeline message.
- One combinational sub-module, `mdu_calc`:
  - inputs: op, rs, rt, hi, lo
  - outputs: 64-bit result and a `dz` flag for divide by zero
- `mdu` holds the counter, pending regs, and HI/LO.

## Test plan
- Reset mid-DIV: start DIV, drop reset at cycle 3 → busy = 0, hi = lo = 0 immediately, and no later commit.
- MULT: rs = 0xFFFFFFFE (−2), rt = 3 → busy high for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. MULTU on the same operands → hi = 0x00000002, lo = 0xFFFFFFFA.
- DIV: rs = −7, rt = 2 → after 10 cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU: 7 / 2 → lo = 3, hi = 1.
- Divide by zero: set hi = 0x11, lo = 0x22 via MTHI/MTLO, then DIV by 0 → busy for 10 cycles, and hi/lo remain 0x11/0x22.
- Start while busy: MULT 2×3, then a DIVU 9/4 start at busy cycle 2 → the DIVU is ignored, and the result is lo = 6, hi = 0 after exactly 5 cycles.
- MADD (with `MDU_MADD_EN`): hi = 0, lo = 0xFFFFFFFF, MADD 1×1 → hi = 1, lo = 0. Without the macro → no busy, and hi/lo are unchanged.
